// File: rtl/multicycle_control_if.sv
// Signal bundle between the multi-cycle controller and its memories and register file.
// The controller connects through the master modport. The environment connects through the slave modport.
interface multicycle_control_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic [PC_W-1:0] imemAddr;
    logic [7:0]      imemData;
    logic [1:0]      readRegister1;
    logic [1:0]      readRegister2;
    logic [7:0]      readData1;
    logic [7:0]      readData2;
    logic            regWrite;
    logic [1:0]      writeRegister;
    logic [7:0]      regWriteData;
    logic [7:0]      dmemAddr;
    logic [7:0]      dmemWriteData;
    logic            dmemWrite;
    logic [7:0]      dmemReadData;
    logic [PC_W-1:0] pc;
    logic [2:0]      state;
    logic            retire;

    modport master (
        input  run, imemData, readData1, readData2, dmemReadData,
        output imemAddr, readRegister1, readRegister2, regWrite, writeRegister,
               regWriteData, dmemAddr, dmemWriteData, dmemWrite, pc, state, retire
    );

    modport slave (
        output run, imemData, readData1, readData2, dmemReadData,
        input  imemAddr, readRegister1, readRegister2, regWrite, writeRegister,
               regWriteData, dmemAddr, dmemWriteData, dmemWrite, pc, state, retire
    );
endinterface

// File: rtl/multicycle_control.sv
// Fetch/decode/execute controller for the 8-bit, 4-register datapath.
// J takes 3 cycles, ADD and SW take 4, and LW takes 5. Instructions never overlap.
module multicycle_control #(
    parameter int PC_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } op_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [7:0]      ir, a, b, alu_out, mdr;
    op_t             op;
    logic [7:0]      imm_ext;
    logic [PC_W-1:0] jmp_off;

    // Last driven value of each select/data output, so they hold while idle.
    logic [1:0] wr_sel_q, wr_sel;
    logic [7:0] wr_data_q, wr_data;
    logic [7:0] dmem_addr_q, dmem_addr;
    logic [7:0] dmem_wdata_q, dmem_wdata;

    assign op      = op_t'(ir[7:6]);
    assign imm_ext = {{6{ir[1]}}, ir[1:0]};
    assign jmp_off = {{(PC_W-6){ir[5]}}, ir[5:0]};

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d                = FETCH;
        bus.regWrite           = 1'b0;
        bus.dmemWrite          = 1'b0;
        bus.retire             = 1'b0;
        wr_sel                 = wr_sel_q;
        wr_data                = wr_data_q;
        dmem_addr              = dmem_addr_q;
        dmem_wdata             = dmem_wdata_q;
        case (state_q)
            FETCH:  state_d = bus.run ? DECODE : FETCH;
            DECODE: state_d = EXEC;
            EXEC: begin
                case (op)
                    OP_ADD:       state_d = WB;
                    OP_LW, OP_SW: state_d = MEM;
                    default: begin
                        state_d    = FETCH;
                        bus.retire = 1'b1;
                    end
                endcase
            end
            MEM: begin
                dmem_addr = alu_out;
                if (op == OP_SW) begin
                    dmem_wdata    = b;
                    bus.dmemWrite = 1'b1;
                    bus.retire    = 1'b1;
                    state_d       = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                bus.regWrite = 1'b1;
                bus.retire   = 1'b1;
                wr_sel       = (op == OP_LW) ? ir[3:2] : ir[1:0];
                wr_data      = (op == OP_LW) ? mdr : alu_out;
                state_d      = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            wr_sel_q     <= '0;
            wr_data_q    <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            wr_sel_q     <= wr_sel;
            wr_data_q    <= wr_data;
            dmem_addr_q  <= dmem_addr;
            dmem_wdata_q <= dmem_wdata;
            case (state_q)
                FETCH: begin
                    if (bus.run) begin
                        ir   <= bus.imemData;
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                DECODE: begin
                    a <= bus.readData1;
                    b <= bus.readData2;
                end
                EXEC: begin
                    case (op)
                        OP_ADD:       alu_out <= a + b;
                        OP_LW, OP_SW: alu_out <= a + imm_ext;
                        default:      pc_q    <= pc_q + jmp_off;
                    endcase
                end
                MEM: begin
                    if (op == OP_LW) mdr <= bus.dmemReadData;
                end
                default: ;
            endcase
        end
    end

    // Register selects come straight from IR, which holds its fields until the next fetch.
    assign bus.imemAddr      = pc_q;
    assign bus.pc            = pc_q;
    assign bus.state         = state_q;
    assign bus.readRegister1 = ir[5:4];
    assign bus.readRegister2 = ir[3:2];
    assign bus.writeRegister = wr_sel;
    assign bus.regWriteData  = wr_data;
    assign bus.dmemAddr      = dmem_addr;
    assign bus.dmemWriteData = dmem_wdata;
endmodule
